fifo_delay_multi: RTL

Time-multiplexed, multi-channel sample delay line holding all channels in one block RAM, each channel in its own region with an independently programmable delay. Parametrised successor to the single-channel BRAM delay FIFO: generalised in width, depth and channel count, single clock with a sample-rate enable strobe, with defined warm-up and length-change behaviour. Sits in the effects path (reverb/echo comb and all-pass taps), between the voice mixer and the effect summing stage.

---
 rtl/fifo_delay_pkg.sv | 24 ++
 rtl/bram_sdp.sv | 22 ++
 rtl/fifo_delay_multi.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fifo_delay_pkg.sv
// Shared types and helpers for the multi-channel BRAM delay line.
// FSM states, length clamp and default address width.
package fifo_delay_pkg;

  localparam int MAXLEN_D   = 2048;
  localparam int CHANNELS_D = 4;
  localparam int AW = $clog2(MAXLEN_D) + $clog2(CHANNELS_D);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  function automatic logic [31:0] clamp_len(
    input logic [31:0] l,
    input logic [31:0] maxlen
  );
    return (l == 32'd0) ? 32'd1 :
           (l > maxlen) ? maxlen : l;
  endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// Storage is not reset.
module bram_sdp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_delay_multi.sv
// Time-multiplexed multi-channel delay line in one block RAM.
// One READ/WRITE slot pair per channel per sample sweep.
module fifo_delay_multi
  import fifo_delay_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAXLEN   = 2048,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_en,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [CHANNELS*32-1:0]    len,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int PW = $clog2(MAXLEN);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LW = PW + 1;
  localparam int ADDR_W = CW + PW;
  localparam logic [LW-1:0] FULL = LW'(MAXLEN);
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  state_t state, state_n;

  logic [CW-1:0]             ch;
  logic [PW-1:0]             ptr   [CHANNELS];
  logic [LW-1:0]             fill  [CHANNELS];
  logic [LW-1:0]             len_q [CHANNELS];
  logic [LW-1:0]             len_c [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] in_q;
  logic [ADDR_W-1:0]         addr;
  logic [WIDTH-1:0]          rdata;
  logic                      last;
  logic                      wr;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      len_c[c] = LW'(clamp_len(len[c*32 +: 32], 32'(MAXLEN)));
    end
  end

  // Regions are power-of-two sized, so c*MAXLEN+ptr is a concatenation.
  assign addr = {ch, ptr[ch]};
  assign last = (ch == LAST);
  assign wr   = (state == WRITE);

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  bram_sdp #(
    .DATA_WIDTH(WIDTH),
    .ADDR_WIDTH(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr),
    .waddr(addr),
    .wdata(in_q[ch*WIDTH +: WIDTH]),
    .raddr(addr),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (sample_en) state_n = READ;
      READ:    state_n = WRITE;
      WRITE:   state_n = last ? DONE : READ;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch      <= '0;
      in_q    <= '0;
      out     <= '0;
      overrun <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr[c]   <= '0;
        fill[c]  <= '0;
        len_q[c] <= '0;
      end
    end else begin
      if (sample_en && state != IDLE) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (sample_en) begin
            ch   <= '0;
            in_q <= in;
            for (int c = 0; c < CHANNELS; c++) begin
              len_q[c] <= len_c[c];
              // A new length restarts warm-up so stale data is masked.
              if (len_c[c] != len_q[c]) begin
                ptr[c]  <= '0;
                fill[c] <= '0;
              end
            end
          end
        end
        WRITE: begin
          out[ch*WIDTH +: WIDTH] <=
            (fill[ch] >= len_q[ch]) ? rdata : '0;
          ptr[ch] <= ({1'b0, ptr[ch]} == len_q[ch] - 1'b1) ?
                     '0 : ptr[ch] + 1'b1;
          if (fill[ch] < FULL) fill[ch] <= fill[ch] + 1'b1;
          if (!last) ch <= ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
